// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two valid/ready requesters.
// Winner's operands are registered onto the ALU, held EXEC_CYCLES, then the result is captured.
module alu_arbiter #(
  parameter int DW          = 8,
  parameter int OPW         = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           req0_ready,
  output logic           req0_done,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           req1_ready,
  output logic           req1_done,
  output logic [DW-1:0]  rsp_rslt,
  output logic           rsp_taken,
  output logic           busy,
  output logic           owner,
  output logic [OPW-1:0] ALUOp,
  output logic [DW-1:0]  inA,
  output logic [DW-1:0]  inB,
  input  logic [DW-1:0]  rslt,
  input  logic           taken
);

  generate
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("alu_arbiter: EXEC_CYCLES must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_cnt;
  logic           r_last_grant;
  logic           r_owner;
  logic [OPW-1:0] r_alu_op;
  logic [DW-1:0]  r_in_a;
  logic [DW-1:0]  r_in_b;
  logic [DW-1:0]  r_rsp_rslt;
  logic           r_rsp_taken;

  logic           w_any;
  logic           w_sel;
  logic           w_accept;
  logic [OPW-1:0] w_sel_op;
  logic [DW-1:0]  w_sel_a;
  logic [DW-1:0]  w_sel_b;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    w_any    = req0_valid | req1_valid;
    w_sel    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    w_sel_op = w_sel ? req1_op : req0_op;
    w_sel_a  = w_sel ? req1_a  : req0_a;
    w_sel_b  = w_sel ? req1_b  : req0_b;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          req0_ready   = ~w_sel;
          req1_ready   = w_sel;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        req0_done    = ~r_owner;
        req1_done    = r_owner;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_op     <= '0;
      r_in_a       <= '0;
      r_in_b       <= '0;
      r_rsp_rslt   <= '0;
      r_rsp_taken  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_alu_op     <= w_sel_op;
        r_in_a       <= w_sel_a;
        r_in_b       <= w_sel_b;
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
        r_cnt        <= CNT_LOAD;
      end
      // ALU inputs stay untouched here, so the combinational result settles before capture.
      if (r_state == S_EXEC) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rsp_rslt  <= rslt;
          r_rsp_taken <= taken;
        end
      end
    end
  end

  assign ALUOp     = r_alu_op;
  assign inA       = r_in_a;
  assign inB       = r_in_b;
  assign rsp_rslt  = r_rsp_rslt;
  assign rsp_taken = r_rsp_taken;
  assign owner     = r_owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a cycle-count transaction model. ALU stub: rslt=inA^inB, taken=(inA==inB).
module tb_alu_arbiter;

  int n_cmp = 0;
  int n_err = 0;

  logic       Clk;
  logic       Reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req0_done, req1_ready, req1_done;
  logic [7:0] rsp_rslt, inA, inB, rslt;
  logic       rsp_taken, busy, owner, taken;
  logic [2:0] ALUOp;

  logic       d3_req0_valid, d3_req1_valid;
  logic [2:0] d3_req0_op, d3_req1_op;
  logic [7:0] d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
  logic       d3_req0_ready, d3_req0_done, d3_req1_ready, d3_req1_done;
  logic [7:0] d3_rsp_rslt, d3_inA, d3_inB, d3_rslt;
  logic       d3_rsp_taken, d3_busy, d3_owner, d3_taken;
  logic [2:0] d3_ALUOp;

  logic [2:0] h_op;
  logic [7:0] h_a, h_b;

  assign rslt     = inA ^ inB;
  assign taken    = (inA == inB);
  assign d3_rslt  = d3_inA ^ d3_inB;
  assign d3_taken = (d3_inA == d3_inB);

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  alu_arbiter #(.DW(8), .OPW(3), .EXEC_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .rsp_rslt(rsp_rslt), .rsp_taken(rsp_taken), .busy(busy), .owner(owner),
    .ALUOp(ALUOp), .inA(inA), .inB(inB), .rslt(rslt), .taken(taken)
  );

  alu_arbiter #(.DW(8), .OPW(3), .EXEC_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(d3_req0_valid), .req0_op(d3_req0_op), .req0_a(d3_req0_a), .req0_b(d3_req0_b),
    .req0_ready(d3_req0_ready), .req0_done(d3_req0_done),
    .req1_valid(d3_req1_valid), .req1_op(d3_req1_op), .req1_a(d3_req1_a), .req1_b(d3_req1_b),
    .req1_ready(d3_req1_ready), .req1_done(d3_req1_done),
    .rsp_rslt(d3_rsp_rslt), .rsp_taken(d3_rsp_taken), .busy(d3_busy), .owner(d3_owner),
    .ALUOp(d3_ALUOp), .inA(d3_inA), .inB(d3_inB), .rslt(d3_rslt), .taken(d3_taken)
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    d3_req0_op = '0; d3_req0_a = '0; d3_req0_b = '0;
    d3_req1_op = '0; d3_req1_a = '0; d3_req1_b = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_ready, req1_ready, req0_done, req1_done, busy, owner, rsp_taken} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b exp %b",
               {req0_ready, req1_ready, req0_done, req1_done, busy, owner, rsp_taken}, 7'b0);
    end
    n_cmp++;
    if ({ALUOp, inA, inB, rsp_rslt} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_data got %h exp %h", {ALUOp, inA, inB, rsp_rslt}, 27'h0);
    end
    n_cmp++;
    if ({d3_busy, d3_owner, d3_ALUOp, d3_inA, d3_inB, d3_rsp_rslt} !== 29'h0) begin
      n_err++;
      $display("FAIL reset_dut3 got %h exp %h",
               {d3_busy, d3_owner, d3_ALUOp, d3_inA, d3_inB, d3_rsp_rslt}, 29'h0);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clk);
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'hA0; req0_b = 8'h06;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      n_err++; $display("FAIL single_ready got %b exp %b", {req0_ready, req1_ready, busy}, 3'b100);
    end
    @(negedge Clk);
    req0_valid = 1'b0; req0_a = 8'($urandom); req0_b = 8'($urandom);
    #1;
    n_cmp++;
    if ({ALUOp, inA, inB, busy, req0_done} !== {3'b001, 8'hA0, 8'h06, 2'b10}) begin
      n_err++;
      $display("FAIL single_issue got %h exp %h", {ALUOp, inA, inB, busy, req0_done},
               {3'b001, 8'hA0, 8'h06, 2'b10});
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_done, req1_done, busy, owner, rsp_taken, rsp_rslt} !== {5'b10100, 8'hA6}) begin
      n_err++;
      $display("FAIL single_done got %h exp %h", {req0_done, req1_done, busy, owner, rsp_taken, rsp_rslt},
               {5'b10100, 8'hA6});
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({busy, req0_done} !== 2'b00) begin
      n_err++; $display("FAIL single_after got %b exp %b", {busy, req0_done}, 2'b00);
    end
    $display("single txn port 0 rslt %02h", rsp_rslt);
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge Clk);
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'h11; req0_b = 8'h90;
    req1_valid = 1'b1; req1_op = 3'd5; req1_a = 8'h80; req1_b = 8'h80;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL sim_first_grant got %b exp %b", {req0_ready, req1_ready}, 2'b10);
    end
    @(negedge Clk);
    req0_valid = 1'b0;
    #1;
    n_cmp++;
    if ({req1_ready, busy} !== 2'b01) begin
      n_err++; $display("FAIL sim_wait_exec got %b exp %b", {req1_ready, busy}, 2'b01);
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_done, req1_done, req1_ready, owner, rsp_taken, rsp_rslt} !== {5'b10000, 8'h81}) begin
      n_err++;
      $display("FAIL sim_done0 got %h exp %h", {req0_done, req1_done, req1_ready, owner, rsp_taken, rsp_rslt},
               {5'b10000, 8'h81});
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_ready, req1_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL sim_second_grant got %b exp %b", {req0_ready, req1_ready, busy}, 3'b010);
    end
    @(negedge Clk);
    req1_valid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ALUOp, inA, inB} !== {1'b1, 3'd5, 8'h80, 8'h80}) begin
      n_err++; $display("FAIL sim_issue1 got %h exp %h", {busy, ALUOp, inA, inB}, {1'b1, 3'd5, 8'h80, 8'h80});
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_done, req1_done, owner, rsp_taken, rsp_rslt} !== {4'b0111, 8'h00}) begin
      n_err++;
      $display("FAIL sim_done1 got %h exp %h", {req0_done, req1_done, owner, rsp_taken, rsp_rslt},
               {4'b0111, 8'h00});
    end
    $display("simultaneous txns port 0 then port 1 complete");
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int dones = 0;
    int last_done = -1;
    bit acc0 = 1'b0;
    bit acc1 = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    req0_valid = 1'b1; req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_valid = 1'b1; req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (acc0) begin req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom); acc0 = 1'b0; end
      if (acc1) begin req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom); acc1 = 1'b0; end
      if (grants >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      n_cmp++;
      if ((req0_ready & req1_ready) !== 1'b0 || (req0_done & req1_done) !== 1'b0) begin
        n_err++;
        $display("FAIL rr_exclusive cyc %0d got rdy %b%b done %b%b exp no pair", c,
                 req0_ready, req1_ready, req0_done, req1_done);
      end
      if (req0_ready | req1_ready) begin
        n_cmp++;
        if (req1_ready !== grants[0]) begin
          n_err++; $display("FAIL rr_grant_order grant %0d got port %0d exp %0d", grants, req1_ready, grants[0]);
        end
        exp_q.push_back(req1_ready ? (req1_a ^ req1_b) : (req0_a ^ req0_b));
        $display("rr txn %0d granted to port %0d", grants, req1_ready);
        acc0 = req0_ready; acc1 = req1_ready;
        grants++;
      end
      if (req0_done | req1_done) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (rsp_rslt !== exp_v || req1_done !== dones[0]) begin
          n_err++;
          $display("FAIL rr_done %0d got rslt %02h port %0d exp rslt %02h port %0d", dones, rsp_rslt,
                   req1_done, exp_v, dones[0]);
        end
        if (last_done >= 0) begin
          n_cmp++;
          if (c - last_done != 3) begin
            n_err++; $display("FAIL rr_done_spacing got %0d exp %0d", c - last_done, 3);
          end
        end
        last_done = c;
        dones++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (grants != 4 || dones != 4) begin
      n_err++; $display("FAIL rr_counts got grants %0d dones %0d exp 4 4", grants, dones);
    end
  endtask

  task automatic test_exec3();
    logic [2:0] op;
    @(negedge Clk);
    op = 3'($urandom);
    d3_req1_valid = 1'b1; d3_req1_op = op; d3_req1_a = 8'h0F; d3_req1_b = 8'hF0;
    #1;
    n_cmp++;
    if ({d3_req0_ready, d3_req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL ex3_ready got %b exp %b", {d3_req0_ready, d3_req1_ready}, 2'b01);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      d3_req1_valid = 1'b0; d3_req1_a = 8'($urandom); d3_req1_b = 8'($urandom); d3_req1_op = 3'($urandom);
      #1;
      n_cmp++;
      if ({d3_ALUOp, d3_inA, d3_inB, d3_busy, d3_req0_done, d3_req1_done} !== {op, 8'h0F, 8'hF0, 3'b100}) begin
        n_err++;
        $display("FAIL ex3_hold cyc %0d got %h exp %h", k, {d3_ALUOp, d3_inA, d3_inB, d3_busy, d3_req0_done,
                 d3_req1_done}, {op, 8'h0F, 8'hF0, 3'b100});
      end
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({d3_req0_done, d3_req1_done, d3_owner, d3_rsp_taken, d3_rsp_rslt} !== {4'b0110, 8'hFF}) begin
      n_err++;
      $display("FAIL ex3_done got %h exp %h", {d3_req0_done, d3_req1_done, d3_owner, d3_rsp_taken,
               d3_rsp_rslt}, {4'b0110, 8'hFF});
    end
    @(negedge Clk); #1;
    n_cmp++;
    if ({d3_busy, d3_req1_done} !== 2'b00) begin
      n_err++; $display("FAIL ex3_after got %b exp %b", {d3_busy, d3_req1_done}, 2'b00);
    end
    $display("exec3 txn port 1 rslt %02h", d3_rsp_rslt);
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    req0_valid = 1'b1; req0_op = 3'($urandom_range(1, 7));
    req0_a = 8'($urandom_range(1, 255)); req0_b = 8'($urandom);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_accept got %b exp %b", req0_ready, 1'b1);
    end
    @(negedge Clk);
    req0_valid = 1'b0; Reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_in_exec got %b exp %b", busy, 1'b1);
    end
    @(negedge Clk);
    Reset = 1'b0;
    h_op = 3'($urandom); h_a = 8'($urandom); h_b = 8'($urandom);
    req0_valid = 1'b1; req0_op = h_op; req0_a = h_a; req0_b = h_b;
    req1_valid = 1'b1; req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    #1;
    n_cmp++;
    if ({req0_done, req1_done, busy, owner, rsp_taken} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_ctl got %b exp %b", {req0_done, req1_done, busy, owner, rsp_taken}, 5'b0);
    end
    n_cmp++;
    if ({ALUOp, inA, inB, rsp_rslt} !== 27'h0) begin
      n_err++; $display("FAIL mid_data got %h exp %h", {ALUOp, inA, inB, rsp_rslt}, 27'h0);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL mid_tie_grant got %b exp %b", {req0_ready, req1_ready}, 2'b10);
    end
    $display("reset-abort txn dropped, tie after reset granted to port %0d", req1_ready);
  endtask

  task automatic test_hold();
    logic [27:0] exp_d;
    @(negedge Clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge Clk); #1;
    n_cmp++;
    if ({req0_done, rsp_rslt, rsp_taken} !== {1'b1, h_a ^ h_b, h_a == h_b}) begin
      n_err++;
      $display("FAIL hold_done got %h exp %h", {req0_done, rsp_rslt, rsp_taken}, {1'b1, h_a ^ h_b, h_a == h_b});
    end
    exp_d = {h_op, h_a, h_b, h_a ^ h_b, h_a == h_b};
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      req0_a = 8'($urandom); req1_a = 8'($urandom);
      #1;
      n_cmp++;
      if ({ALUOp, inA, inB, rsp_rslt, rsp_taken} !== exp_d ||
          {req0_ready, req1_ready, req0_done, req1_done, busy} !== 5'b0) begin
        n_err++;
        $display("FAIL hold_idle cyc %0d got %h/%b exp %h/%b", k, {ALUOp, inA, inB, rsp_rslt, rsp_taken},
                 {req0_ready, req1_ready, req0_done, req1_done, busy}, exp_d, 5'b0);
      end
    end
    $display("hold txn port 0 rslt %02h kept over idle", rsp_rslt);
  endtask

  // Model: an op accepted in cycle c completes in cycle c+1+EC, the ALU is free again at c+2+EC.
  task automatic test_random();
    localparam int EC = 1;
    bit p0 = 1'b0, p1 = 1'b0, m_last = 1'b1, m_owner = 1'b0, m_taken = 1'b0, pend_taken = 1'b0;
    bit e_r0, e_r1, e_d0, e_d1, e_busy, w;
    int done_at = -10, free_at = 0, ntx = 0;
    logic [2:0] m_op = '0;
    logic [7:0] m_a = '0, m_b = '0, m_rslt = '0, pend_rslt = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      if (!p0 && c < 380 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) req0_b = req0_a;
      end
      if (!p1 && c < 380 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) req1_b = req1_a;
      end
      req0_valid = p0; req1_valid = p1;
      #1;
      if (c == done_at) begin m_rslt = pend_rslt; m_taken = pend_taken; end
      e_busy = (c < free_at);
      w = (p0 && p1) ? !m_last : p1;
      e_r0 = !e_busy && (p0 || p1) && !w;
      e_r1 = !e_busy && (p0 || p1) && w;
      e_d0 = (c == done_at) && !m_owner;
      e_d1 = (c == done_at) && m_owner;
      n_cmp++;
      if ({req0_ready, req1_ready, req0_done, req1_done, busy, owner} !== {e_r0, e_r1, e_d0, e_d1, e_busy, m_owner}) begin
        n_err++;
        $display("FAIL rnd_ctl cyc %0d got %b exp %b", c, {req0_ready, req1_ready, req0_done, req1_done, busy, owner},
                 {e_r0, e_r1, e_d0, e_d1, e_busy, m_owner});
      end
      n_cmp++;
      if ({ALUOp, inA, inB, rsp_rslt, rsp_taken} !== {m_op, m_a, m_b, m_rslt, m_taken}) begin
        n_err++;
        $display("FAIL rnd_data cyc %0d got %h exp %h", c, {ALUOp, inA, inB, rsp_rslt, rsp_taken},
                 {m_op, m_a, m_b, m_rslt, m_taken});
      end
      if (e_r0 || e_r1) begin
        m_op = w ? req1_op : req0_op;
        m_a  = w ? req1_a  : req0_a;
        m_b  = w ? req1_b  : req0_b;
        pend_rslt = m_a ^ m_b; pend_taken = (m_a == m_b);
        m_owner = w; m_last = w;
        done_at = c + 1 + EC; free_at = done_at + 1;
        if (w) p1 = 1'b0; else p0 = 1'b0;
        $display("rnd txn %0d port %0d op %0d a %02h b %02h", ntx, w, m_op, m_a, m_b);
        ntx++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_exec3();
    test_reset_mid();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters, e.g. port 0 = execute stage and port 1 = branch/address helper.
- Uses a valid/ready handshake per requester and round-robin arbitration.
- Registers the winner's opcode and operands onto the ALU inputs, waits EXEC_CYCLES, captures rslt/taken, and pulses done to the owner.
- Sits between the control/datapath logic and the alu instance. It is the only driver of ALUOp, inA and inB.

Parameters:
- DW, 8, operand/result width.
- OPW, 3, ALUOp width.
- EXEC_CYCLES, 1, cycles the issued operands are held on the ALU before capture (1..15).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_op  input  OPW  requester 0 opcode.
- req0_a  input  DW  requester 0 operand A.
- req0_b  input  DW  requester 0 operand B.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_done  output  1  one-cycle pulse: result for requester 0 valid.
- req1_valid, req1_op, req1_a, req1_b, req1_ready, req1_done  same as requester 0, for requester 1.
- rsp_rslt  output  DW  captured ALU result (shared by both requesters).
- rsp_taken  output  1  captured ALU taken flag.
- busy  output  1  high in EXEC and DONE.
- owner  output  1  id of the requester currently/last served.
- ALUOp  output  OPW  to ALU, registered.
- inA  output  DW  to ALU, registered.
- inB  output  DW  to ALU, registered.
- rslt  input  DW  from ALU, combinational.
- taken  input  1  from ALU, combinational.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - state=IDLE, cnt=0, last_grant=1 (so req0 wins the first tie).
  - ALUOp/inA/inB=0, rsp_rslt=0, rsp_taken=0, owner=0.
  - All ready/done/busy outputs are 0. Reset has priority over every other event.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Winner selection:
    - Only reqX_valid is high → X wins.
    - Both high → the id != last_grant wins.
    - Neither high → stay in IDLE.
  - reqX_ready is combinational: high only in IDLE for the winner. It is never high for both ports, and never high outside IDLE.
  - On the edge where valid&ready: latch op/a/b into ALUOp/inA/inB, owner=X, last_grant=X, cnt=EXEC_CYCLES-1, go to EXEC.
  - Requesters hold valid, op and operands stable until accepted. After acceptance their inputs are don't-care.
- EXEC:
  - ALUOp/inA/inB are held constant.
  - cnt!=0 → cnt decrements.
  - cnt==0 → capture rslt into rsp_rslt and taken into rsp_taken, go to DONE.
- DONE:
  - req<owner>_done=1 for exactly this cycle. rsp_rslt/rsp_taken are valid.
  - Go to IDLE. No request is accepted in DONE.
- Timing:
  - Latency: accept edge at the end of cycle N → done high in cycle N+1+EXEC_CYCLES.
  - Throughput: one operation per EXEC_CYCLES+2 cycles.
- Output hold rules:
  - rsp_rslt/rsp_taken hold their value until the next capture; they are not cleared in IDLE.
  - ALUOp/inA/inB keep the last issued values while IDLE.
- Fairness: while one requester is busy, the waiting requester's valid stays high with ready=0. It wins the next IDLE if the other port also re-requests immediately, so the ports alternate.
- busy=1 in EXEC and DONE, 0 in IDLE.
- Reset mid-operation (EXEC or DONE): abort to IDLE with no done pulse; outputs return to reset values.
- Width rules: all data paths are exactly DW bits, with no extension or truncation. EXEC_CYCLES=0 is illegal (elaboration assertion).

Test Plan:
- Bench ALU stub for all scenarios: rslt=inA^inB, taken=(inA==inB).
- Single request:
  - Stimulus: after reset, req0 op=001, a=0xA0, b=0x06, held until ready.
  - Required: req0_ready high in the first valid cycle; ALUOp=001, inA=0xA0 on the next cycle; req0_done one cycle later with rsp_rslt=0xA6, rsp_taken=0, owner=0; busy high for 2 cycles.
- Simultaneous requests after reset:
  - Stimulus: req0 (a=0x11, b=0x90) and req1 (a=0x80, b=0x80) both valid.
  - Required: req0 is granted first and gives rsp_rslt=0x81. req1 sees ready=0 while busy, is granted in the IDLE cycle after req0_done, and gives rsp_rslt=0x00, taken=1, req1_done only.
- Round-robin:
  - Stimulus: both requesters keep valid high for 4 operations.
  - Required: grants alternate 0,1,0,1; done pulses are 3 cycles apart; no cycle has both ready or both done high.
- EXEC_CYCLES=3:
  - Stimulus: req1 a=0x0F, b=0xF0.
  - Required: inputs to the ALU are stable for 3 cycles; req1_done arrives 4 cycles after the accept edge with rsp_rslt=0xFF.
- Reset mid-operation:
  - Stimulus: assert Reset for 1 cycle while in EXEC.
  - Required: no done pulse; ALUOp/inA/inB/rsp_rslt=0 and busy=0 next cycle; a subsequent req0 and req1 tie grants req0.
- Hold behaviour:
  - Stimulus: complete one operation, then leave both valids low for 5 cycles.
  - Required: rsp_rslt, rsp_taken, ALUOp, inA and inB keep their last values; ready/done stay 0.
